seq_significand_mult: RTL



---
 rtl/fpu_mul_pkg.sv | 27 ++
 rtl/seq_mult_pp_gen.sv | 15 +
 rtl/seq_significand_mult.sv | 111 +++++++++++
 3 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared FP multiplier types: significand widths, sequencer states, sideband and rounding-mode codes.
// Pure declarations, no latency, no flow control.
package fpu_mul_pkg;

    localparam int FRAC_W = 23;
    localparam int SIG_W  = 24;
    localparam int PROD_W = 48;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding agreed with the rounding stage
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    typedef struct packed {
        logic       sz;
        logic [1:0] r_mode;
    } side_t;

endpackage

// File: rtl/seq_mult_pp_gen.sv
// Partial product A * B[BPC-1:0], combinational, no backpressure.
// Output is SIG_W+BPC wide so the product of one BPC-bit slice never overflows.
module seq_mult_pp_gen
    import fpu_mul_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [SIG_W-1:0]     a,
    input  logic [BPC-1:0]       b_bits,
    output logic [SIG_W+BPC-1:0] pp
);

    assign pp = {{BPC{1'b0}}, a} * {{SIG_W{1'b0}}, b_bits};

endmodule

// File: rtl/seq_significand_mult.sv
// Iterative 24x24 significand multiplier, BPC bits per cycle; out_valid ITER edges after accept, holds in DONE until out_ready.
// in_ready only in IDLE. Option SEQ_MULT_EARLY_ZERO_EN: zero operand skips straight to DONE at the accept edge.
module seq_significand_mult
    import fpu_mul_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] Mx,
    input  logic [FRAC_W-1:0] My,
    input  logic              zero_Ex,
    input  logic              zero_Ey,
    input  logic              Sz,
    input  logic [1:0]        R_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] P,
    output logic              out_Sz,
    output logic [1:0]        out_R_mode
);

    localparam int              ITER   = SIG_W / BPC;
    localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

    state_t                 state;
    logic [SIG_W-1:0]       a_q;
    logic [SIG_W-1:0]       acc_hi;
    logic [SIG_W-1:0]       b_lo;
    logic [CNT_W-1:0]       cnt;
    side_t                  side_q;
    logic [SIG_W-1:0]       a_in;
    logic [SIG_W-1:0]       b_in;
    logic [SIG_W+BPC-1:0]   pp;
    logic [SIG_W+BPC-1:0]   sum;

    assign a_in = {~zero_Ex, Mx};
    assign b_in = {~zero_Ey, My};

    seq_mult_pp_gen #(.BPC(BPC)) u_pp_gen (
        .a      (a_q),
        .b_bits (b_lo[BPC-1:0]),
        .pp     (pp)
    );

    // Wide sum keeps the step carry; b_lo doubles as the low product half as multiplier bits retire.
    assign sum = {{BPC{1'b0}}, acc_hi} + pp;

    assign in_ready   = (state == IDLE) && !rst;
    assign out_Sz     = side_q.sz;
    assign out_R_mode = side_q.r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            acc_hi    <= '0;
            b_lo      <= '0;
            cnt       <= '0;
            side_q    <= '0;
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a_in;
                        b_lo   <= b_in;
                        acc_hi <= '0;
                        cnt    <= ITER_C;
                        side_q <= '{sz: Sz, r_mode: R_mode};
`ifdef SEQ_MULT_EARLY_ZERO_EN
                        if (a_in == '0 || b_in == '0) begin
                            P         <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc_hi <= sum[SIG_W+BPC-1:BPC];
                    b_lo   <= {sum[BPC-1:0], b_lo[SIG_W-1:BPC]};
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        P         <= {sum, b_lo[SIG_W-1:BPC]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
